// File: rtl/ram_acc_pkg.sv
// Shared types and constants for the byte-wide RAM access sequencer.
// RAM_ACC_ALIGN_CHK_EN (optional) enables data-word misalignment errors.
package ram_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int BEATS_WORD = 4;
    localparam int BEATS_BYTE = 1;

    // Index of the final beat for a given access size.
    function automatic logic [1:0] last_beat(input logic size);
        return (size == SIZE_WORD) ? 2'(BEATS_WORD - 1) : 2'(BEATS_BYTE - 1);
    endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Requester and RAM-side signals of the RAM access sequencer.
// d_err exists only when RAM_ACC_ALIGN_CHK_EN is defined.
interface ram_access_ctrl_if #(parameter int ADDR_W = 8);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              d_req;
    logic              d_we;
    logic              d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_done;
`ifdef RAM_ACC_ALIGN_CHK_EN
    logic              d_err;
`endif
    logic              busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport slave (
`ifdef RAM_ACC_ALIGN_CHK_EN
        output d_err,
`endif
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_rdata,
        output if_rdata, if_done, d_rdata, d_done, busy,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
`ifdef RAM_ACC_ALIGN_CHK_EN
        input  d_err,
`endif
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_rdata,
        input  if_rdata, if_done, d_rdata, d_done, busy,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-way round-robin arbiter (fetch vs data); grants only while enabled.
module ram_rr_arbiter
    import ram_acc_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic req_f,
    input  logic req_d,
    output logic gnt_vld,
    output gnt_t gnt_id
);
    gnt_t last;

    always_comb begin
        gnt_vld = en && (req_f || req_d);
        if (req_f && req_d)
            gnt_id = (last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        else if (req_f)
            gnt_id = GNT_FETCH;
        else
            gnt_id = GNT_DATA;
    end

    // Reset to data so fetch wins the first tie.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            last <= GNT_DATA;
        else if (gnt_vld)
            last <= gnt_id;
    end
endmodule

// File: rtl/ram_access_ctrl.sv
// Shares the byte-wide RAM between fetch and load/store, splitting each access
// into big-endian one-byte beats. Optional RAM_ACC_ALIGN_CHK_EN flags misaligned data words.
module ram_access_ctrl
    import ram_acc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic clk,
    input  logic clr,
    ram_access_ctrl_if.slave bus
);
    state_t            state, nstate;
    gnt_t              req_id;
    logic [ADDR_W-1:0] base;
    logic              we_q, size_q;
    logic [3:0][7:0]   wdata_q, rbuf, rword;
    logic [31:0]       if_rdata_q, d_rdata_q;
    logic [1:0]        cnt;
    logic              gnt_vld, mis, g_word;
    gnt_t              gnt_id;
    logic [ADDR_W-1:0] g_addr;
    logic              last;

    ram_rr_arbiter u_arb (
        .clk(clk), .clr(clr), .en(state == ST_IDLE),
        .req_f(bus.if_req), .req_d(bus.d_req),
        .gnt_vld(gnt_vld), .gnt_id(gnt_id)
    );

    assign g_addr = (gnt_id == GNT_FETCH) ? bus.if_addr : bus.d_addr;
    assign g_word = (gnt_id == GNT_FETCH) || (bus.d_size == SIZE_WORD);
    assign last   = (cnt == last_beat(size_q));

`ifdef RAM_ACC_ALIGN_CHK_EN
    logic err_q;
    assign mis = (gnt_id == GNT_DATA) && (bus.d_size == SIZE_WORD) && (bus.d_addr[1:0] != 2'b00);
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            err_q <= 1'b0;
        else if (state == ST_IDLE && gnt_vld)
            err_q <= mis;
    end
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= ST_IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: if (gnt_vld) nstate = mis ? ST_DONE : ST_XFER;
            ST_XFER: if (last) nstate = ST_DONE;
            default: nstate = ST_IDLE;
        endcase
    end

    // Current beat's byte dropped into lane 3-k of the partially assembled word.
    always_comb begin
        rword       = rbuf;
        rword[~cnt] = bus.ram_rdata;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            req_id     <= GNT_FETCH;
            base       <= '0;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            wdata_q    <= '0;
            rbuf       <= '0;
            cnt        <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == ST_IDLE && gnt_vld) begin
            req_id  <= gnt_id;
            base    <= g_word ? {g_addr[ADDR_W-1:2], 2'b00} : g_addr;
            we_q    <= (gnt_id == GNT_DATA) && bus.d_we;
            size_q  <= g_word ? SIZE_WORD : SIZE_BYTE;
            wdata_q <= (gnt_id == GNT_DATA) ? bus.d_wdata : '0;
            cnt     <= '0;
        end else if (state == ST_XFER) begin
            cnt <= cnt + 2'd1;
            if (!we_q) begin
                rbuf <= rword;
                if (last) begin
                    if (req_id == GNT_FETCH)
                        if_rdata_q <= rword;
                    else if (size_q == SIZE_WORD)
                        d_rdata_q <= rword;
                    else
                        d_rdata_q <= {24'h0, bus.ram_rdata};
                end
            end
        end
    end

    always_comb begin
        bus.ram_en    = (state == ST_XFER);
        bus.ram_we    = (state == ST_XFER) && we_q;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (state == ST_XFER) begin
            bus.ram_addr = base + ADDR_W'(cnt);
            if (we_q)
                bus.ram_wdata = (size_q == SIZE_WORD) ? wdata_q[~cnt] : wdata_q[0];
        end
        bus.if_done  = (state == ST_DONE) && (req_id == GNT_FETCH);
        bus.d_done   = (state == ST_DONE) && (req_id == GNT_DATA);
        bus.busy     = (state != ST_IDLE);
        bus.if_rdata = if_rdata_q;
        bus.d_rdata  = d_rdata_q;
`ifdef RAM_ACC_ALIGN_CHK_EN
        bus.d_err    = (state == ST_DONE) && (req_id == GNT_DATA) && err_q;
`endif
    end
endmodule
